load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator-side controller between the RV32I execute stage and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake and drives word-wide memory reads and writes. Performs byte-lane selection, sign/zero extension on loads, read-modify-write merging for SB/SH, and alignment and funct3 checking. All sub-word handling happens here, so the memory only ever sees word accesses.

## Interface
- ADDR_W, 8, byte-address bits used; word index is req_addr[ADDR_W-1:2] (8 gives 64 words)
- clk  in  1  system clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_f3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
- req_addr  in  32  byte address; bits above ADDR_W-1 ignored
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned access or illegal funct3
- mem_read  out  1  word read strobe
- mem_write  out  1  word write strobe, committed by memory at the next edge
- mem_addr  out  ADDR_W-2  word index
- mem_f3  out  3  constant 3'b010
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data, valid in the same cycle as mem_read

## Operation
- States: IDLE, RD, WR, RESP.
- Acceptance: an edge where req_valid && req_ready. The request fields are latched at that edge and are not sampled again.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0]; half h = addr[1].
- Legality:
  - Load f3 must be in {000,001,010,100,101}.
  - Store f3 must be in {000,001,010}.
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
- Illegal request: IDLE -> RESP with resp_err=1. No memory strobe is issued.
- Load: IDLE -> RD -> RESP.
  - In RD: mem_read=1, and mem_rdata is captured into a holding register.
  - In RESP: resp_rdata = selected lane, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW passes the whole word.
- SW: IDLE -> WR -> RESP. In WR: mem_write=1 and mem_wdata=req_wdata.
- SB/SH: IDLE -> RD -> WR -> RESP.
  - The RD capture is merged with the selected lane(s) of req_wdata.
  - Unselected bytes of the word are preserved.
- RESP -> IDLE unconditionally. There is no response backpressure.
- Strobes: mem_read and mem_write are never both high. Both are 0 outside RD/WR, and both are forced to 0 while rst=1.

## Timing
- Acceptance edge = T.
  - Load: resp_valid high during cycle T+2.
  - SW: resp_valid high during T+2; the memory write commits at the edge ending T+1.
  - SB/SH: resp_valid high during T+3.
  - Error: resp_valid high during T+1.
- req_ready is high again in the cycle after RESP, so the minimum spacing between acceptances is 3 cycles (load/SW).
- Reset values: state IDLE; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata = 0; req_ready = 1 from the first cycle after reset deasserts.
- Reset mid-operation:
  - The transaction is dropped and no response is produced.
  - A pending WR is not issued; memory contents are unchanged.
- req_valid low in IDLE: stay in IDLE, outputs idle. req_valid is ignored outside IDLE.
- resp_rdata and resp_err are meaningful only while resp_valid=1. They are 0 otherwise.

## Test plan
- SW addr 0x14, data 0xDEADBEEF, then LW 0x14 -> memory word 5 = 0xDEADBEEF; resp_valid at T+2 with resp_rdata 0xDEADBEEF, resp_err 0.
- SB addr 0x15, data 0x0000007F -> word 5 = 0xDEAD7FEF, resp at T+3. Then LB 0x15 -> 0x0000007F; LB 0x17 -> 0xFFFFFFDE; LBU 0x17 -> 0x000000DE.
- SH addr 0x16, data 0xFFFF1234 -> word 5 = 0x12347FEF. Then LH 0x14 -> 0x00007FEF; LHU 0x16 -> 0x00001234; LH 0x16 -> 0x00001234.
- Illegal requests:
  - LW 0x15, SH 0x13 and load f3=011 each give resp_valid=1, resp_err=1 at T+1, with resp_rdata 0.
  - mem_read and mem_write stay 0 throughout.
- Assert rst for one cycle while in RD of an SB to 0x14 -> no mem_write ever, no resp_valid, word 5 unchanged, req_ready=1 the cycle after reset drops.
- Hold req_valid high with LW 0x00 followed by LW 0x04 -> second acceptance exactly 3 cycles after the first. Each request gets exactly one response pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//
// Initiator-side load/store controller sitting between the RV32I execute
// stage and a word-organised data memory. One request is accepted at a time
// over a valid/ready handshake. All sub-word work is done here, so the memory
// only ever sees full-word reads and writes:
//   - byte-lane selection and sign/zero extension for loads
//   - read-modify-write merging for SB/SH
//   - alignment and funct3 legality checking
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     block can accept (IDLE only)
//   req_we        1 = store, 0 = load
//   req_f3        RV32I funct3 of the access
//   req_addr      byte address (bits above ADDR_W-1 ignored)
//   req_wdata     right-justified store data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores, errors and when idle)
//   resp_err      misaligned access or illegal funct3 (with resp_valid)
//   mem_read      word read strobe
//   mem_write     word write strobe
//   mem_addr      word index
//   mem_f3        always word access (3'b010)
//   mem_wdata     full word to write
//   mem_rdata     combinational read data, valid while mem_read is high

module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [2:0]        mem_f3,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  // Request fields captured at acceptance; the request bus is not looked at
  // again for the rest of the transaction.
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  // Word read during RD, used both for load extraction and RMW merging.
  logic [31:0]       hold_q;

  logic              f3_legal;
  logic              align_ok;
  logic              req_bad;
  logic              accept;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  // Address bits above the modelled memory are deliberately ignored.
  logic [31-ADDR_W:0] unused_addr_hi;
  assign unused_addr_hi = req_addr[31:ADDR_W];

  // Legality of the incoming request. funct3[1:0] encodes the access size for
  // every legal encoding (00 byte, 01 half, 10 word), so alignment is judged
  // from those two bits alone; funct3[2] only marks unsigned loads.
  always_comb begin
    f3_legal = 1'b0;
    align_ok = 1'b0;
    if (req_we) begin
      f3_legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010);
    end else begin
      f3_legal = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010) ||
                 (req_f3 == 3'b100) || (req_f3 == 3'b101);
    end
    case (req_f3[1:0])
      2'b00:   align_ok = 1'b1;
      2'b01:   align_ok = ~req_addr[0];
      2'b10:   align_ok = (req_addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    req_bad = ~(f3_legal && align_ok);
  end

  assign accept = (state == IDLE) && req_valid;

  // State register and request capture. Reset drops any transaction in flight,
  // so a pending WR never reaches the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_f3;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        err_q   <= req_bad;
      end
      if (state == RD) begin
        hold_q <= mem_rdata;
      end
    end
  end

  // Next-state logic. Illegal requests go straight to RESP without touching
  // memory; SW skips the read because it overwrites the whole word, while
  // SB/SH need the old word to preserve the unselected bytes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_next = RESP;
          end else if (req_we && (req_f3[1:0] == 2'b10)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction from the captured word, little-endian: byte k sits at
  // bits [8k+7:8k] with k = addr[1:0], half h at bits [16h+15:16h].
  always_comb begin
    byte_sel  = hold_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = hold_q[{addr_q[1], 4'b0000} +: 16];
    load_data = hold_q;
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = hold_q;
    endcase
  end

  // Store word construction: SB/SH overlay the low store bits onto the
  // selected lane(s) of the word read in RD; SW writes the store data as is.
  always_comb begin
    merged = hold_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Outputs are decoded from the state. Everything is gated with rst so the
  // strobes and the response are silent for the whole reset cycle, even
  // though the state register only clears at the next edge.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == RESP) && !rst;
    resp_err   = (state == RESP) && !rst && err_q;
    resp_rdata = ((state == RESP) && !rst && !err_q && !we_q) ? load_data : 32'h0;
    mem_read   = (state == RD) && !rst;
    mem_write  = (state == WR) && !rst;
    mem_wdata  = ((state == WR) && !rst) ? merged : 32'h0;
    mem_addr   = addr_q[ADDR_W-1:2];
    mem_f3     = 3'b010;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Bench for load_store_unit. A word memory model answers mem_read
// combinationally and commits mem_write at the clock edge. Requests come from
// a table of records; each accepted request pushes its expected response and
// due cycle onto a scoreboard queue that is popped when resp_valid appears.
// Hand-written sequences cover reset during a read-modify-write and
// back-to-back requests with req_valid held high.

module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_f3 = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [2:0]        mem_f3;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_f3     (req_f3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_f3     (mem_f3),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        chk_mem;
    int          mem_idx;
    logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic [31:0] mem [64];
  logic        preload = 1'b1;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          fails = 0;
  exp_t        sb[$];
  vec_t        vecs[$];

  assign mem_rdata = mem[mem_addr];

  // Memory model plus cycle and strobe counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 + i;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int lat, input int rd, input int wr,
                              input logic chk_mem, input int mem_idx, input logic [31:0] exp_mem);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr; v.chk_mem = chk_mem; v.mem_idx = mem_idx; v.exp_mem = exp_mem;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and check what the DUT shows there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (mem_read || mem_write) checkOutput("strobe_exclusive", 64'(mem_read & mem_write), 64'd0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected no response", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
          checkOutput("resp_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        checkOutput("idle_resp_zero", {31'h0, resp_err, resp_rdata}, 64'd0);
      end
    end
  endtask

  task automatic waitReady();
    for (int i = 0; i < 10; i++) begin
      if (req_ready) return;
      tick();
    end
    checks++;
    fails++;
    $display("[TB] FAIL ready_timeout: got req_ready=0 expected 1 within 10 cycles");
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) return;
      tick();
    end
    checks++;
    fails++;
    $display("[TB] FAIL resp_timeout: got %0d outstanding responses expected 0", sb.size());
    sb.delete();
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    int   rd0;
    int   wr0;
    waitReady();
    req_valid = 1'b1;
    req_we    = v.we;
    req_f3    = v.f3;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.due   = cyc + v.exp_lat;
    sb.push_back(e);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    tick();
    req_valid = 1'b0;
    waitDrain();
    checkOutput($sformatf("vec%0d_reads", idx), 64'(rd_cnt - rd0), 64'(v.exp_rd));
    checkOutput($sformatf("vec%0d_writes", idx), 64'(wr_cnt - wr0), 64'(v.exp_wr));
    if (v.chk_mem) checkOutput($sformatf("vec%0d_mem", idx), 64'(mem[v.mem_idx]), 64'(v.exp_mem));
  endtask

  initial begin
    exp_t e;
    int   wr0;
    int   rd0;

    //           we  f3     addr   wdata         rdata         err lat rd wr chk idx mem
    vecs.push_back(mk(1, 3'b010, 32'h14, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 1, 5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'b010, 32'h14, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h15, 32'h0000007F, 32'h0,        0, 3, 1, 1, 1, 5, 32'hDEAD7FEF));
    vecs.push_back(mk(0, 3'b000, 32'h15, 32'h0,        32'h0000007F, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h17, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'h17, 32'h0,        32'h000000DE, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h16, 32'hFFFF1234, 32'h0,        0, 3, 1, 1, 1, 5, 32'h12347FEF));
    vecs.push_back(mk(0, 3'b001, 32'h14, 32'h0,        32'h00007FEF, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h16, 32'h0,        32'h00001234, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h16, 32'h0,        32'h00001234, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h15, 32'h0,        32'h0,        1, 1, 0, 0, 1, 5, 32'h12347FEF));
    vecs.push_back(mk(1, 3'b001, 32'h13, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 1, 4, 32'hA5A50004));
    vecs.push_back(mk(0, 3'b011, 32'h14, 32'h0,        32'h0,        1, 1, 0, 0, 0, 5, 32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h14, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 1, 5, 32'h12347FEF));
    vecs.push_back(mk(0, 3'b001, 32'h17, 32'h0,        32'h0,        1, 1, 0, 0, 0, 5, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h14, 32'hFFFFFF80, 32'h0,        0, 3, 1, 1, 1, 5, 32'h12347F80));
    vecs.push_back(mk(0, 3'b000, 32'h14, 32'h0,        32'hFFFFFF80, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h16, 32'h00008001, 32'h0,        0, 3, 1, 1, 1, 5, 32'h80017F80));
    vecs.push_back(mk(0, 3'b001, 32'h16, 32'h0,        32'hFFFF8001, 0, 2, 1, 0, 0, 5, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h18, 32'h0,        32'hA5A50006, 0, 2, 1, 0, 0, 6, 32'h0));

    // Reset state.
    repeat (3) tick();
    preload = 1'b0;
    rst = 1'b0;
    tick();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_strobes", {62'h0, mem_read, mem_write}, 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("mem_f3", 64'(mem_f3), 64'd2);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Reset while an SB is in its read cycle: nothing may be written or reported.
    $display("[TB] reset during SB read-modify-write");
    waitReady();
    wr0 = wr_cnt;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_f3    = 3'b000;
    req_addr  = 32'h14;
    req_wdata = 32'h000000AA;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_ready", 64'(req_ready), 64'd1);
    repeat (4) tick();
    checkOutput("rst_mid_writes", 64'(wr_cnt - wr0), 64'd0);
    checkOutput("rst_mid_mem", 64'(mem[5]), 64'h80017F80);
    applyStimulus(mk(0, 3'b010, 32'h14, 32'h0, 32'h80017F80, 0, 2, 1, 0, 0, 5, 32'h0), 100);

    // req_valid held high across two loads: second acceptance 3 cycles later.
    $display("[TB] back-to-back loads with req_valid held");
    waitReady();
    rd0 = rd_cnt;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_f3    = 3'b010;
    req_addr  = 32'h00;
    e.rdata = 32'hA5A50000; e.err = 1'b0; e.due = cyc + 2;
    sb.push_back(e);
    e.rdata = 32'hA5A50001; e.err = 1'b0; e.due = cyc + 5;
    sb.push_back(e);
    tick();
    req_addr = 32'h04;
    repeat (3) tick();
    req_valid = 1'b0;
    waitDrain();
    repeat (4) tick();
    checkOutput("b2b_reads", 64'(rd_cnt - rd0), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
